// File: rtl/vred_pkg.sv
// Shared opcodes, element-width encodings, FSM states and identity helpers
// for the multi-beat vector reduction unit.
package vred_pkg;

  localparam logic [2:0] VRED_SUM  = 3'd0;
  localparam logic [2:0] VRED_AND  = 3'd1;
  localparam logic [2:0] VRED_OR   = 3'd2;
  localparam logic [2:0] VRED_XOR  = 3'd3;
  localparam logic [2:0] VRED_MINU = 3'd4;
  localparam logic [2:0] VRED_MIN  = 3'd5;
  localparam logic [2:0] VRED_MAXU = 3'd6;
  localparam logic [2:0] VRED_MAX  = 3'd7;

  localparam logic [1:0] VRED_SEW8  = 2'd0;
  localparam logic [1:0] VRED_SEW16 = 2'd1;
  localparam logic [1:0] VRED_SEW32 = 2'd2;
  localparam logic [1:0] VRED_SEW64 = 2'd3;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} vred_state_e;

  function automatic logic [63:0] vred_sew_mask(input logic [1:0] sew);
    logic [63:0] m;
    case (sew)
      VRED_SEW8:  m = 64'h0000_0000_0000_00FF;
      VRED_SEW16: m = 64'h0000_0000_0000_FFFF;
      VRED_SEW32: m = 64'h0000_0000_FFFF_FFFF;
      default:    m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] vred_sign_bit(input logic [1:0] sew);
    logic [63:0] m;
    m = vred_sew_mask(sew);
    return m ^ (m >> 1);
  endfunction

  // Value that leaves any operand unchanged under op, truncated to the element width.
  function automatic logic [63:0] vred_identity(input logic [2:0] op, input logic [1:0] sew);
    logic [63:0] m;
    logic [63:0] r;
    m = vred_sew_mask(sew);
    case (op)
      VRED_AND, VRED_MINU: r = m;
      VRED_MIN:            r = m >> 1;
      VRED_MAX:            r = vred_sign_bit(sew);
      default:             r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vred_combine.sv
// Two-operand, element-width-aware combine node used by the lane tree and the
// accumulator. Result bits above the element width are always zero.
module vred_combine
  import vred_pkg::*;
#(
  parameter int MIN_MAX_ENABLE = 1,
  parameter int LOGIC_ENABLE   = 1
) (
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_sew,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_y
);

  logic [63:0] w_m;
  logic [63:0] w_sb;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [63:0] w_sum;
  logic        w_lt_u;
  logic        w_lt_s;

  always_comb begin
    w_m    = vred_sew_mask(i_sew);
    w_sb   = vred_sign_bit(i_sew);
    w_a    = i_a & w_m;
    w_b    = i_b & w_m;
    w_sum  = (w_a + w_b) & w_m;
    w_lt_u = w_a < w_b;
    // Flipping the element sign bit turns a signed compare into an unsigned one.
    w_lt_s = (w_a ^ w_sb) < (w_b ^ w_sb);
    o_y    = w_sum;
    case (i_op)
      VRED_AND:  if (LOGIC_ENABLE != 0)   o_y = w_a & w_b;
      VRED_OR:   if (LOGIC_ENABLE != 0)   o_y = w_a | w_b;
      VRED_XOR:  if (LOGIC_ENABLE != 0)   o_y = w_a ^ w_b;
      VRED_MINU: if (MIN_MAX_ENABLE != 0) o_y = w_lt_u ? w_a : w_b;
      VRED_MIN:  if (MIN_MAX_ENABLE != 0) o_y = w_lt_s ? w_a : w_b;
      VRED_MAXU: if (MIN_MAX_ENABLE != 0) o_y = w_lt_u ? w_b : w_a;
      VRED_MAX:  if (MIN_MAX_ENABLE != 0) o_y = w_lt_s ? w_b : w_a;
      default:   o_y = w_sum;
    endcase
  end

endmodule

// File: rtl/vred_accum_unit.sv
// Multi-beat vector reduction: masked lane tree per beat (stage 1), scalar
// accumulator seeded by vs1[0] (stage 2), valid/ready on both sides.
module vred_accum_unit
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH     = 128,
  parameter int OPSEL_WIDTH    = 3,
  parameter int SEW_WIDTH      = 2,
  parameter int MIN_MAX_ENABLE = 1,
  parameter int LOGIC_ENABLE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic [63:0]             seed,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OPSEL_WIDTH-1:0]  opSel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_data
);

  localparam int unsigned N  = DATA_WIDTH / 8;
  localparam int unsigned LG = $clog2(N);
  localparam int unsigned NP = 1 << LG;

  vred_state_e r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [63:0] r_out_data;

  logic [2:0]  r_op;
  logic [1:0]  r_sew;
  logic [63:0] r_seed;
  logic        r_s1_vld;
  logic        r_s1_first;
  logic        r_s1_last;
  logic [63:0] r_s1_part;
  logic [63:0] r_acc;
  logic        r_s2_done;

  logic [2:0]      w_op_req;
  logic [2:0]      w_op;
  logic [1:0]      w_sew;
  logic [63:0]     w_ident;
  logic [31:0]     w_cnt;
  logic [NP*8-1:0] w_data_p;
  logic [NP-1:0]   w_mask_p;
  logic [63:0]     w_tree;
  logic [63:0]     w_acc_in;
  logic [63:0]     w_fold;
  logic            w_accept;
  logic            w_take;

  // Opcodes whose hardware is compiled out collapse onto sum, identity included.
  always_comb begin
    w_op_req = 3'(opSel);
    if (MIN_MAX_ENABLE == 0 && w_op_req[2]) w_op_req = VRED_SUM;
    if (LOGIC_ENABLE == 0 && !w_op_req[2] && w_op_req != VRED_SUM) w_op_req = VRED_SUM;
  end

  assign w_op     = in_first ? w_op_req : r_op;
  assign w_sew    = in_first ? 2'(sew) : r_sew;
  assign w_ident  = vred_identity(w_op, w_sew);
  assign w_cnt    = 32'(N) >> w_sew;
  assign w_data_p = (NP*8)'(in_data);
  assign w_mask_p = NP'(in_mask);
  assign w_accept = in_valid & r_in_ready;
  assign w_take   = w_accept & (in_first | (r_state == ACC));

  // Tree padded to a power of two; absent and masked-off slots carry the identity.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [63:0] w_v [NP >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_slot
        logic [63:0] w_e [4];
        for (genvar s = 0; s < 4; s++) begin : g_w
          if (i < (NP >> s)) begin : g_in
            assign w_e[s] = 64'(w_data_p[i*(8<<s) +: (8<<s)]);
          end else begin : g_out
            assign w_e[s] = '0;
          end
        end
        assign w_v[i] = (w_mask_p[i] && (32'(i) < w_cnt)) ? w_e[w_sew] : w_ident;
      end
    end else begin : g_node
      for (genvar k = 0; k < (NP >> l); k++) begin : g_k
        vred_combine #(
          .MIN_MAX_ENABLE(MIN_MAX_ENABLE),
          .LOGIC_ENABLE  (LOGIC_ENABLE)
        ) u_comb (
          .i_op (w_op),
          .i_sew(w_sew),
          .i_a  (g_lvl[l-1].w_v[2*k]),
          .i_b  (g_lvl[l-1].w_v[2*k+1]),
          .o_y  (w_v[k])
        );
      end
    end
  end

  assign w_tree   = g_lvl[LG].w_v[0];
  assign w_acc_in = r_s1_first ? r_seed : r_acc;

  vred_combine #(
    .MIN_MAX_ENABLE(MIN_MAX_ENABLE),
    .LOGIC_ENABLE  (LOGIC_ENABLE)
  ) u_acc (
    .i_op (r_op),
    .i_sew(r_sew),
    .i_a  (w_acc_in),
    .i_b  (r_s1_part),
    .o_y  (w_fold)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= VRED_SUM;
      r_sew      <= VRED_SEW8;
      r_seed     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_part  <= '0;
      r_acc      <= '0;
      r_s2_done  <= 1'b0;
    end else begin
      r_s1_vld  <= w_take;
      r_s2_done <= r_s1_vld & r_s1_last;
      if (w_take) begin
        r_s1_part  <= w_tree;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end
      if (w_take && in_first) begin
        r_seed <= seed;
        r_op   <= w_op_req;
        r_sew  <= 2'(sew);
      end
      if (r_s1_vld) r_acc <= w_fold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept && in_first) begin
            if (in_last) begin
              r_state    <= FLUSH;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (w_accept && in_last) begin
            r_state    <= FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (r_s2_done) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_vred_accum_unit.sv
// Directed and randomized checks of vred_accum_unit against an element-by-element
// reduction model.
module tb_vred_accum_unit;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW/8-1:0] in_mask = '0;
  logic [63:0]   seed = '0;
  logic [1:0]    sew = '0;
  logic [2:0]    opSel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]   q_data[$];
  logic [DW/8-1:0] q_mask[$];

  vred_accum_unit #(
    .DATA_WIDTH    (DW),
    .OPSEL_WIDTH   (3),
    .SEW_WIDTH     (2),
    .MIN_MAX_ENABLE(1),
    .LOGIC_ENABLE  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .seed     (seed),
    .sew      (sew),
    .opSel    (opSel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mask(input int sw);
    return (sw == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << sw)) - 64'd1);
  endfunction

  function automatic longint ref_sx(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic [63:0] ref_op(input int op, input int sw, input logic [63:0] a, input logic [63:0] b);
    int w;
    logic [63:0] m;
    logic [63:0] r;
    w = 8 << sw;
    m = ref_mask(sw);
    case (op)
      0: r = (a + b) & m;
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: r = (a < b) ? a : b;
      5: r = (ref_sx(a, w) < ref_sx(b, w)) ? a : b;
      6: r = (a > b) ? a : b;
      default: r = (ref_sx(a, w) > ref_sx(b, w)) ? a : b;
    endcase
    return r;
  endfunction

  // Sequential fold of every enabled element of every queued beat onto the seed.
  function automatic logic [63:0] ref_reduce(input int op, input int sw, input logic [63:0] sd);
    int w;
    logic [63:0] m;
    logic [63:0] acc;
    logic [63:0] e;
    logic [DW-1:0] d;
    logic [DW/8-1:0] mk;
    w = 8 << sw;
    m = ref_mask(sw);
    acc = sd & m;
    for (int b = 0; b < q_data.size(); b++) begin
      d = q_data[b];
      mk = q_mask[b];
      for (int i = 0; i < DW / w; i++) begin
        if (mk[i]) begin
          e = 64'(d >> (i * w)) & m;
          acc = ref_op(op, sw, acc, e);
        end
      end
    end
    return acc;
  endfunction

  task automatic send_beat(input logic first, input logic last, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] mk, input logic [63:0] sd, input int sw, input int op);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_first = first; in_last = last; in_data = d;
    in_mask = mk; seed = sd; sew = 2'(sw); opSel = 3'(op);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_queue(input int op, input int sw, input logic [63:0] sd, input bit gaps);
    int nb;
    nb = q_data.size();
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      if (b == 0) send_beat(1'b1, nb == 1, q_data[0], q_mask[0], sd, sw, op);
      else send_beat(1'b0, b == nb - 1, q_data[b], q_mask[b], {$urandom(), $urandom()},
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end
  endtask

  // Called right after the last beat's accepting edge; in_valid stays high throughout.
  task automatic get_result(input string tag, input logic [63:0] exp, input int hold);
    @(posedge clk); #1;
    check({tag, "_valid_at_1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid_at_2"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_data"}, out_data, exp);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    logic [63:0]   sd;
    logic [63:0]   exp;
    int            op;
    int            sw;
    int            nb;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 1);
    q_data = {d}; q_mask = {16'hFFFF};
    send_queue(0, 0, 64'd0, 1'b0);
    get_result("sum8", 64'h88, 0);

    d  = {32'd9, 32'd7, 32'hFFFF_FFFD, 32'd5};
    d2 = {32'd1, 32'd0, 32'd2, 32'hFFFF_FFF8};
    q_data = {d, d2}; q_mask = {16'hFFFF, 16'hFFFF};
    send_queue(5, 2, 64'd100, 1'b0);
    get_result("min32", 64'hFFFF_FFF8, 1);
    send_queue(4, 2, 64'd100, 1'b0);
    get_result("minu32", 64'd0, 0);
    send_queue(7, 2, 64'hFFFF_FFF0, 1'b0);
    get_result("max32", 64'd9, 0);

    q_data = {{64'd0, 64'd1}}; q_mask = {16'hFFFF};
    send_queue(0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    get_result("sum64_wrap", 64'd0, 0);

    q_data = {{$urandom(), $urandom(), $urandom(), $urandom()}}; q_mask = {16'h0000};
    send_queue(1, 1, 64'h1234, 1'b0);
    get_result("and16_masked", 64'h1234, 0);

    q_data = {{$urandom(), $urandom(), $urandom(), $urandom()}}; q_mask = {16'hFFFF};
    exp = ref_reduce(0, 0, 64'h5A);
    send_queue(0, 0, 64'h5A, 1'b0);
    get_result("backpressure", exp, 5);

    send_beat(1'b0, 1'b1, '1, 16'hFFFF, 64'd7, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("drop_out_valid", 64'(out_valid), 64'd0);
      check("drop_in_ready", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;

    send_beat(1'b1, 1'b0, '1, 16'hFFFF, 64'd3, 0, 0);
    q_data = {{$urandom(), $urandom(), $urandom(), $urandom()}}; q_mask = {16'h0F0F};
    exp = ref_reduce(6, 1, 64'h8001);
    send_queue(6, 1, 64'h8001, 1'b0);
    get_result("restart_maxu16", exp, 0);

    send_beat(1'b1, 1'b0, '1, 16'hFFFF, 64'd9, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    q_data = {{DW{1'b1}}}; q_mask = {16'hFFFF};
    send_queue(3, 0, 64'd0, 1'b0);
    get_result("xor8_after_rst", 64'd0, 0);

    for (int t = 0; t < 30; t++) begin
      op = int'($urandom_range(0, 7));
      sw = int'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 3));
      sd = {$urandom(), $urandom()};
      q_data.delete(); q_mask.delete();
      for (int b = 0; b < nb; b++) begin
        q_data.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        case ($urandom_range(0, 3))
          0: q_mask.push_back(16'h0000);
          1: q_mask.push_back(16'hFFFF);
          default: q_mask.push_back(16'($urandom()));
        endcase
      end
      exp = ref_reduce(op, sw, sd);
      send_queue(op, sw, sd, 1'b1);
      get_result("rnd", exp, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
